timer_irq_gen: RTL and testbench
================================

// Module: timer_irq_gen
// PURPOSE
// - Memory-mapped down-counting timer; sole source of the CPU external 'interrupt' input.
// - The CPU programs it through a word-addressed bus slave port. 'irq' drives mips.interrupt.
// - Two modes: one-shot with a level-held IRQ, or auto-reload with a periodic 1-cycle IRQ pulse.
// PARAMETERS
// - PRESCALE_W    8        prescaler register width; used only with TIMER_PRESCALE_EN
// - RESET_PRESET  32'h0    PRESET register value after reset
// PORTS
// - clk     in   1   system clock; all state updates on posedge
// - reset   in   1   asynchronous reset, active-low (0 = reset)
// - addr    in   2   word select: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 PRESCALE
// - we      in   1   write strobe; wdata sampled at posedge while high
// - wdata   in   32  write data
// - rdata   out  32  combinational read of the register selected by addr
// - irq     out  1   interrupt request = CTRL.IM & irq_flag
// BEHAVIOUR
// - CTRL bits: [0] EN (count enable), [2:1] MODE (00 one-shot, 01 auto-reload, others = one-shot), [3] IM (irq mask).
//   Bits [31:4] read 0 and are ignored on write.
// - Reset (reset==0, async): CTRL=0, PRESET=RESET_PRESET, COUNT=0, PRESCALE=0, irq_flag=0, state=IDLE. irq=0.
// - FSM states and transitions:
//   - IDLE -> LOAD when EN=1.
//   - LOAD: COUNT<=PRESET; -> CNT.
//   - CNT:
//     - EN=0: hold COUNT, stay in CNT (pause).
//     - EN=1, COUNT>1: COUNT<=COUNT-1.
//     - EN=1, COUNT<=1: COUNT<=0, -> INT.
//   - INT, MODE one-shot: irq_flag<=1, EN<=0, -> IDLE.
//   - INT, MODE auto-reload: irq_flag<=1 for exactly one cycle, -> LOAD.
// - Latency, one-shot with PRESET=N (N>=1): irq rises at the (N+3)th posedge after the posedge that writes EN=1.
//   PRESET=0 behaves as N=1.
// - Period, auto-reload: irq pulses every N+2 cycles (INT + LOAD + N CNT cycles). Pulse width is 1 cycle.
// - One-shot irq_flag holds until any CTRL or PRESET write; that write clears it on the same edge.
// - A PRESET write during CNT does not change COUNT; the new value applies at the next LOAD.
// - A CTRL write with EN=0 while in CNT pauses counting. Rewriting EN=1 resumes from the held COUNT.
// - Simultaneous CPU CTRL write and INT-state EN clear: the CPU write wins.
//   irq_flag is still set in auto-reload; in one-shot it is cleared by the write.
// - COUNT never wraps below 0. Writes to addr 2 are ignored.
// - Reset asserted mid-count aborts immediately. All state returns to reset values with no irq glitch.
// CONFIGURATION
// - TIMER_PRESCALE_EN defined:
//   - addr 3 is a PRESCALE_W-bit R/W register.
//   - In CNT, COUNT decrements once per PRESCALE+1 enabled cycles.
//   - The internal divider clears on LOAD and on any PRESCALE write.
//   - One-shot latency becomes N*(PRESCALE+1)+3.
// - TIMER_PRESCALE_EN undefined: addr 3 reads 0, writes are ignored, COUNT decrements every enabled cycle.
// TESTING
// - Reset low mid-sim -> rdata for addr 0/1/2 = 0/RESET_PRESET/0, irq=0 within the same cycle.
// - PRESET=5, CTRL=4'b1001 (IM, one-shot, EN) -> irq rises at the 8th posedge after the CTRL write and stays high;
//   CTRL reads 4'b1000; a CTRL write clears irq.
// - PRESET=3, CTRL=4'b1011 (auto-reload) -> irq is a 1-cycle pulse every 5 cycles, for >=4 periods.
// - PRESET=10, EN=1, then EN=0 after 4 cycles, hold 6 cycles, then EN=1 -> COUNT frozen during pause; total delay extended by 6.
// - PRESET=0, one-shot -> irq at the 4th posedge. IM=0 with the same stimulus -> irq stays 0; a later IM=1 write raises irq.
// - TIMER_PRESCALE_EN: PRESCALE=2, PRESET=4, one-shot -> irq at the 15th posedge; addr 3 reads back 2.

Source files
------------

// File: rtl/timer_irq_gen.sv
// rtl/timer_irq_gen.sv - memory-mapped down-counting timer, sole source of the CPU interrupt
// Define TIMER_PRESCALE_EN to add the PRESCALE_W-bit count prescaler at addr 3.
module timer_irq_gen #(
  parameter int          PRESCALE_W   = 8,
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t                state, state_nxt;
  logic [3:0]            ctrl;
  logic [31:0]           preset;
  logic [31:0]           count;
  logic                  irq_flag;
  logic [PRESCALE_W-1:0] prescale;
  logic                  tick;
  logic                  wr_ctrl, wr_preset, en, auto_reload;

  assign wr_ctrl     = we && (addr == 2'd0);
  assign wr_preset   = we && (addr == 2'd1);
  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] div;
  logic                  wr_prescale;

  assign wr_prescale = we && (addr == 2'd3);
  assign tick        = (div == prescale);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      div      <= '0;
    end else begin
      if (wr_prescale)
        prescale <= wdata[PRESCALE_W-1:0];
      if (wr_prescale || state == LOAD)
        div <= '0;
      else if (state == CNT && en)
        div <= tick ? '0 : div + PRESCALE_W'(1);
    end
  end
`else
  assign prescale = '0;
  assign tick     = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = LOAD;
      LOAD:    state_nxt = CNT;
      CNT:     if (en && tick && count <= 32'd1) state_nxt = INT;
      INT:     state_nxt = auto_reload ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ctrl     <= 4'd0;
      preset   <= RESET_PRESET;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_nxt;

      // A CPU CTRL write overrides the one-shot self-disable on the same edge.
      if (wr_ctrl)
        ctrl <= wdata[3:0];
      else if (state == INT && !auto_reload)
        ctrl[0] <= 1'b0;

      if (wr_preset)
        preset <= wdata;

      if (state == LOAD)
        count <= preset;
      else if (state == CNT && en && tick)
        count <= (count > 32'd1) ? count - 32'd1 : 32'd0;

      // LOAD with the flag up only follows an auto-reload INT, so it ends the pulse.
      if (state == INT)
        irq_flag <= auto_reload || !(wr_ctrl || wr_preset);
      else if (wr_ctrl || wr_preset || state == LOAD)
        irq_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0: rdata = {28'd0, ctrl};
      2'd1: rdata = preset;
      2'd2: rdata = count;
      2'd3: rdata = 32'(prescale);
      default: rdata = 32'd0;
    endcase
  end

  assign irq = ctrl[3] & irq_flag;

endmodule

// File: tb/tb_timer_irq_gen.sv
// tb/tb_timer_irq_gen.sv - randomized and directed self-checking bench for timer_irq_gen
module tb_timer_irq_gen;

  localparam logic [31:0] RP = 32'h0000_0007;
  localparam int          PW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  timer_irq_gen #(.PRESCALE_W(PW), .RESET_PRESET(RP)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Reference model: stage 0 idle, 1 reload, 2 counting, 3 expired
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  logic        m_flag, m_pulse;
  int          m_stage;
`ifdef TIMER_PRESCALE_EN
  int          m_div;
  logic [PW-1:0] m_ps;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc_n, got, exp);
    end
  endtask

  task automatic lit(input string name, input logic got, input logic exp);
    check(name, {31'd0, got}, {31'd0, exp});
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_ctrl};
      2'd1: return m_preset;
      2'd2: return m_count;
`ifdef TIMER_PRESCALE_EN
      default: return 32'(m_ps);
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic m_reset();
    m_ctrl = 4'd0; m_preset = RP; m_count = 32'd0;
    m_flag = 1'b0; m_pulse = 1'b0; m_stage = 0;
`ifdef TIMER_PRESCALE_EN
    m_div = 0; m_ps = '0;
`endif
  endtask

  task automatic m_step();
    logic wc, wp, am, tk;
    logic [3:0] n_ctrl;
    logic [31:0] n_count;
    logic n_flag, n_pulse;
    int n_stage;
`ifdef TIMER_PRESCALE_EN
    int n_div;
    n_div = m_div;
`endif
    wc = we && addr == 2'd0;
    wp = we && addr == 2'd1;
    am = (m_ctrl[2:1] == 2'b01);
    n_ctrl = m_ctrl; n_count = m_count; n_flag = m_flag; n_pulse = 1'b0; n_stage = m_stage;
    tk = 1'b1;
    case (m_stage)
      0: if (m_ctrl[0]) n_stage = 1;
      1: begin
        n_count = m_preset; n_stage = 2;
`ifdef TIMER_PRESCALE_EN
        n_div = 0;
`endif
      end
      2: if (m_ctrl[0]) begin
`ifdef TIMER_PRESCALE_EN
        tk = (m_div == int'(m_ps));
        n_div = tk ? 0 : m_div + 1;
`endif
        if (tk) begin
          if (m_count > 1) n_count = m_count - 1;
          else begin n_count = 32'd0; n_stage = 3; end
        end
      end
      default: begin
        n_flag = 1'b1;
        if (am) begin n_pulse = 1'b1; n_stage = 1; end
        else begin n_ctrl[0] = 1'b0; n_stage = 0; end
      end
    endcase
    if (m_pulse) n_flag = 1'b0;
    if (wc) n_ctrl = wdata[3:0];
    if (wp) m_preset = wdata;
    if ((wc || wp) && !(m_stage == 3 && am)) n_flag = 1'b0;
`ifdef TIMER_PRESCALE_EN
    if (we && addr == 2'd3) begin m_ps = wdata[PW-1:0]; n_div = 0; end
    m_div = n_div;
`endif
    m_ctrl = n_ctrl; m_count = n_count; m_flag = n_flag; m_pulse = n_pulse; m_stage = n_stage;
  endtask

  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d);
    we = w; addr = a; wdata = d;
    @(posedge clk);
    m_step();
    cyc_n++;
    @(negedge clk);
    lit("irq", irq, m_flag & m_ctrl[3]);
    check("rdata", rdata, m_read(addr));
  endtask

  task automatic idle(input logic [1:0] a);
    cyc(1'b0, a, 32'd0);
  endtask

  task automatic do_reset();
    we = 1'b0;
    reset = 1'b0;
    m_reset();
    addr = 2'd0; #1 check("rst_ctrl", rdata, 32'd0);
    addr = 2'd1; #1 check("rst_preset", rdata, RP);
    addr = 2'd2; #1 check("rst_count", rdata, 32'd0);
    addr = 2'd3; #1 check("rst_prescale", rdata, 32'd0);
    lit("rst_irq", irq, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int t0, r;
    logic [31:0] d;
    #1;
    do_reset();

    // One-shot PRESET=5: irq at 8th posedge, CTRL reads back with EN cleared
    cyc(1'b1, 2'd1, 32'd5);
    cyc(1'b1, 2'd0, 32'h9);
    t0 = cyc_n;
    for (int k = 1; k <= 9; k++) begin
      idle(2'd0);
      if (k == 7) lit("os5_k7", irq, 1'b0);
      if (k == 8) lit("os5_k8", irq, 1'b1);
      if (k == 9) check("os5_ctrl", rdata, 32'h8);
    end
    cyc(1'b1, 2'd0, 32'h8);
    lit("os5_clear", irq, 1'b0);

    // Auto-reload PRESET=3: 1-cycle pulse every 5 cycles
    do_reset();
    cyc(1'b1, 2'd1, 32'd3);
    cyc(1'b1, 2'd0, 32'hB);
    t0 = cyc_n;
    for (int k = 1; k <= 26; k++) begin
      idle(2'(k % 4));
      lit("auto_pulse", irq, (k >= 6) && ((k - 6) % 5 == 0));
    end

    // Pause: PRESET=10, EN dropped for 6 enabled-edges
    do_reset();
    cyc(1'b1, 2'd1, 32'd10);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) idle(2'd2);
    cyc(1'b1, 2'd0, 32'h8);
    for (int k = 5; k <= 9; k++) begin
      idle(2'd2);
      check("pause_count", rdata, 32'd8);
    end
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 11; k <= 20; k++) begin
      idle(2'd2);
      if (k == 18) lit("pause_k18", irq, 1'b0);
      if (k == 19) lit("pause_k19", irq, 1'b1);
    end

    // PRESET=0 behaves as 1; masked run then IM=1 rerun
    do_reset();
    cyc(1'b1, 2'd1, 32'd0);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle(2'd2);
      if (k == 3) lit("p0_k3", irq, 1'b0);
      if (k == 4) lit("p0_k4", irq, 1'b1);
    end
    cyc(1'b1, 2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) idle(2'd0);
    lit("masked", irq, 1'b0);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle(2'd0);
      if (k == 4) lit("unmask_k4", irq, 1'b1);
    end

    // COUNT is read-only; prescaler register behaviour
    do_reset();
    cyc(1'b1, 2'd2, 32'h55);
    idle(2'd2);
    check("count_ro", rdata, 32'd0);
    cyc(1'b1, 2'd3, 32'd2);
    idle(2'd3);
`ifdef TIMER_PRESCALE_EN
    check("prescale_rd", rdata, 32'd2);
    cyc(1'b1, 2'd1, 32'd4);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 15; k++) begin
      idle(2'd2);
      if (k == 14) lit("ps_k14", irq, 1'b0);
      if (k == 15) lit("ps_k15", irq, 1'b1);
    end
`else
    check("prescale_rd", rdata, 32'd0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      d = $urandom;
      if (r < 3) do_reset();
      else if (r < 40) begin
        d[0] = ($urandom_range(0, 9) < 8);
        cyc(1'b1, 2'd0, d);
      end
      else if (r < 70) cyc(1'b1, 2'd1, 32'($urandom_range(0, 6)));
      else if (r < 85) cyc(1'b1, 2'd2, d);
      else if (r < 100) cyc(1'b1, 2'd3, 32'($urandom_range(0, 3)));
      else idle(2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
